// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, limits and validity helper
package bcd_pkg;
   typedef logic [3:0] bcd_t;
   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;
   function automatic logic bcd_valid(input bcd_t v);
      return v <= BCD_MAX;
   endfunction
endpackage

// File: rtl/bcd_decade_counter_tick_gen.sv
// tick_gen: enable-gated prescaler emitting a one-cycle tick every DIV enabled clocks
module tick_gen #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] pcnt_q, pcnt_d;
   assign tick = en & (pcnt_q == LAST);
   always_comb pcnt_d = !en ? pcnt_q : tick ? '0 : pcnt_q + 1'b1;
   always_ff @(posedge clk)
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;
endmodule

// File: rtl/bcd_decade_counter.sv
// bcd_decade_counter: prescaled up/down BCD decade with load and carry/borrow for cascading
module bcd_decade_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       cin,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] digit,
   output logic       tick,
   output logic       cout,
   output logic       load_err
);
   bcd_t digit_q, digit_d;
   logic err_q, err_d;
   logic step, term;
   tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .en(en), .tick(tick));
   assign step     = tick & cin;
   assign term     = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
   assign cout     = step & term & ~load;
   assign digit    = digit_q;
   assign load_err = err_q;
   // a load, valid or not, always consumes the cycle's step
   always_comb begin
      err_d   = load & ~bcd_valid(load_val);
      digit_d = load  ? (bcd_valid(load_val) ? load_val : digit_q) :
                !step ? digit_q :
                term  ? (up ? BCD_MIN : BCD_MAX) :
                up    ? digit_q + 4'd1 : digit_q - 4'd1;
   end
   always_ff @(posedge clk)
      if (rst) begin
         digit_q <= BCD_MIN;
         err_q   <= 1'b0;
      end else begin
         digit_q <= digit_d;
         err_q   <= err_d;
      end
endmodule

// File: tb/tb_bcd_decade_counter.sv
// tb_bcd_decade_counter: vector table, corner sequences and random run against an arithmetic model
module tb_bcd_decade_counter;
   logic clk = 1'b0;
   logic rst;
   logic en4, cin4, up4, ld4;
   logic [3:0] lv4, d4;
   logic t4, c4, e4;
   logic enc, upc;
   logic [3:0] dlo, dhi;
   logic tlo, clo, elo, thi, chi, ehi;
   logic en1, up1;
   logic [3:0] d1;
   logic t1, c1, e1;

   bcd_decade_counter #(.DIV(4)) u4 (.clk(clk), .rst(rst), .en(en4), .cin(cin4), .up(up4),
      .load(ld4), .load_val(lv4), .digit(d4), .tick(t4), .cout(c4), .load_err(e4));
   bcd_decade_counter #(.DIV(2)) ulo (.clk(clk), .rst(rst), .en(enc), .cin(1'b1), .up(upc),
      .load(1'b0), .load_val(4'd0), .digit(dlo), .tick(tlo), .cout(clo), .load_err(elo));
   bcd_decade_counter #(.DIV(2)) uhi (.clk(clk), .rst(rst), .en(enc), .cin(clo), .up(upc),
      .load(1'b0), .load_val(4'd0), .digit(dhi), .tick(thi), .cout(chi), .load_err(ehi));
   bcd_decade_counter #(.DIV(1)) u1 (.clk(clk), .rst(rst), .en(en1), .cin(1'b1), .up(up1),
      .load(1'b0), .load_val(4'd0), .digit(d1), .tick(t1), .cout(c1), .load_err(e1));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   typedef struct packed {
      logic en, cin, up, ld;
      logic [3:0] lv, d;
      logic t, c, e;
   } vec_t;
   vec_t tbl [28];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
      checks++;
      if (a !== r) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", n, a, r, $time);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      en4 = 0; cin4 = 0; up4 = 0; ld4 = 0; lv4 = 0;
      enc = 0; upc = 0; en1 = 0; up1 = 0;
      nxt();
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1,1,1,0,4'd0, 4'd0,0,0,0};
      tbl[1]  = '{1,1,1,0,4'd0, 4'd0,0,0,0};
      tbl[2]  = '{1,1,1,0,4'd0, 4'd0,0,0,0};
      tbl[3]  = '{1,1,1,0,4'd0, 4'd0,1,0,0};
      tbl[4]  = '{1,1,1,1,4'd9, 4'd1,0,0,0};
      tbl[5]  = '{1,1,1,0,4'd0, 4'd9,0,0,0};
      tbl[6]  = '{1,1,1,0,4'd0, 4'd9,0,0,0};
      tbl[7]  = '{1,1,1,1,4'd3, 4'd9,1,0,0};
      tbl[8]  = '{1,1,1,1,4'd12,4'd3,0,0,0};
      tbl[9]  = '{0,1,1,0,4'd0, 4'd3,0,0,1};
      tbl[10] = '{0,1,1,0,4'd0, 4'd3,0,0,0};
      tbl[11] = '{1,1,0,0,4'd0, 4'd3,0,0,0};
      tbl[12] = '{1,1,0,0,4'd0, 4'd3,0,0,0};
      tbl[13] = '{1,0,0,0,4'd0, 4'd3,1,0,0};
      tbl[14] = '{1,1,0,0,4'd0, 4'd3,0,0,0};
      tbl[15] = '{1,1,0,0,4'd0, 4'd3,0,0,0};
      tbl[16] = '{1,1,0,0,4'd0, 4'd3,0,0,0};
      tbl[17] = '{1,1,0,0,4'd0, 4'd3,1,0,0};
      tbl[18] = '{0,1,0,1,4'd0, 4'd2,0,0,0};
      tbl[19] = '{1,1,0,0,4'd0, 4'd0,0,0,0};
      tbl[20] = '{1,1,0,0,4'd0, 4'd0,0,0,0};
      tbl[21] = '{1,1,0,0,4'd0, 4'd0,0,0,0};
      tbl[22] = '{1,1,0,0,4'd0, 4'd0,1,1,0};
      tbl[23] = '{1,1,1,0,4'd0, 4'd9,0,0,0};
      tbl[24] = '{1,1,1,1,4'd10,4'd9,0,0,0};
      tbl[25] = '{1,1,1,0,4'd0, 4'd9,0,0,1};
      tbl[26] = '{1,1,1,0,4'd0, 4'd9,1,1,0};
      tbl[27] = '{1,1,1,0,4'd0, 4'd0,0,0,0};

      do_reset();
      #4;
      chk("rst_digit", d4, 0);
      chk("rst_tick", t4, 0);
      chk("rst_cout", c4, 0);
      chk("rst_err", e4, 0);
      nxt();

      // vector table
      do_reset();
      for (int i = 0; i < 28; i++) begin
         en4 = tbl[i].en; cin4 = tbl[i].cin; up4 = tbl[i].up; ld4 = tbl[i].ld; lv4 = tbl[i].lv;
         #4;
         chk($sformatf("vec%0d_digit", i), d4, tbl[i].d);
         chk($sformatf("vec%0d_tick", i), t4, tbl[i].t);
         chk($sformatf("vec%0d_cout", i), c4, tbl[i].c);
         chk($sformatf("vec%0d_err", i), e4, tbl[i].e);
         nxt();
      end

      // up count 44 cycles
      do_reset();
      for (int c = 0; c < 44; c++) begin
         en4 = 1; cin4 = 1; up4 = 1;
         #4;
         chk("up_tick", t4, (c % 4) == 3);
         chk("up_digit", d4, (c / 4) % 10);
         chk("up_cout", c4, ((c % 4) == 3) && ((c / 4) % 10 == 9));
         nxt();
      end

      // down count from reset
      do_reset();
      for (int c = 0; c < 24; c++) begin
         en4 = 1; cin4 = 1; up4 = 0;
         #4;
         chk("dn_digit", d4, (10 - (c / 4) % 10) % 10);
         chk("dn_cout", c4, ((c % 4) == 3) && (c / 4 == 0));
         nxt();
      end

      // en dropped mid-prescale, then reset with digit=5
      do_reset();
      for (int c = 0; c < 6; c++) begin en4 = 1; cin4 = 1; up4 = 1; nxt(); end
      for (int c = 0; c < 10; c++) begin
         en4 = 0;
         #4;
         chk("frz_tick", t4, 0);
         chk("frz_digit", d4, 1);
         nxt();
      end
      en4 = 1;
      #4; chk("resume_tick0", t4, 0); nxt();
      #4; chk("resume_tick1", t4, 1); nxt();
      for (int c = 0; c < 14; c++) nxt();
      #4; chk("pre_rst_digit", d4, 5); chk("pre_rst_tick", t4, 0);
      rst = 1; nxt(); rst = 0;
      for (int c = 0; c < 4; c++) begin
         #4;
         chk("post_rst_digit", d4, c == 3 ? 0 : 0);
         chk("post_rst_tick", t4, c == 3);
         nxt();
      end
      #4; chk("post_rst_step", d4, 1); nxt();

      // two cascaded decades
      do_reset();
      for (int c = 0; c < 204; c++) begin
         enc = 1; upc = 1;
         #4;
         chk("casc_value", 32'(dhi) * 10 + 32'(dlo), (c / 2) % 100);
         chk("casc_lo_cout", clo, (c % 2 == 1) && ((c / 2) % 10 == 9));
         nxt();
      end

      // DIV=1 with direction toggling every cycle
      do_reset();
      for (int c = 0; c < 20; c++) begin
         en1 = 1; up1 = (c % 2) == 0;
         #4;
         chk("div1_tick", t1, 1);
         chk("div1_digit", d1, c % 2);
         chk("div1_cout", c1, 0);
         nxt();
      end

      // random stimulus against arithmetic model
      do_reset();
      begin
         int pc = 0, dg = 0;
         bit er = 0, xt, xs, tm, xc;
         for (int i = 0; i < 3000; i++) begin
            rst  = $urandom_range(0, 63) == 0;
            en4  = $urandom_range(0, 3) != 0;
            cin4 = $urandom_range(0, 3) != 0;
            up4  = 1'($urandom);
            ld4  = $urandom_range(0, 7) == 0;
            lv4  = 4'($urandom);
            #4;
            xt = en4 && pc == 3;
            xs = xt && cin4;
            tm = up4 ? dg == 9 : dg == 0;
            xc = xs && tm && !ld4;
            chk("rnd_digit", d4, dg);
            chk("rnd_tick", t4, xt);
            chk("rnd_cout", c4, xc);
            chk("rnd_err", e4, er);
            if (rst) begin
               dg = 0; pc = 0; er = 0;
            end else begin
               er = ld4 && lv4 > 9;
               if (ld4) begin
                  if (lv4 <= 9) dg = int'(lv4);
               end else if (xs) dg = up4 ? (dg + 1) % 10 : (dg + 9) % 10;
               if (en4) pc = (pc + 1) % 4;
            end
            nxt();
         end
         rst = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
